// File: rtl/s444_bist_pkg.sv
// Shared definitions for the s444 BIST controller.
// Holds the controller state encoding, the 16-bit LFSR/MISR feedback taps
// (x^16 + x^14 + x^13 + x^11, taken from bits 15,13,12,10), the default
// pattern seed, the response width and the bit position of each s444
// primary output inside the packed RESP word.
package s444_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam int unsigned RESP_W    = 6;
    localparam int unsigned RESP_G107 = 0;
    localparam int unsigned RESP_G108 = 1;
    localparam int unsigned RESP_G118 = 2;
    localparam int unsigned RESP_G119 = 3;
    localparam int unsigned RESP_G167 = 4;
    localparam int unsigned RESP_G168 = 5;

    // One left shift of the Fibonacci register; feedback is the XOR of the taps.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci shift register used both as the pattern generator and
// as the response compactor (MISR).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (reset to RESET_VAL)
//   load        parallel load of load_val (wins over shift_en)
//   shift_en    advance one step, XORing xor_in into the shifted value
//   xor_in      parallel compaction input (tie to zero for a plain LFSR)
//   q           current register contents
module bist_lfsr16
    import s444_bist_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        shift_en,
    input  logic [15:0] xor_in,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= lfsr_step(q) ^ xor_in;
        end
    end

endmodule

// File: rtl/s444_bist_ctrl.sv
// BIST controller for the s444 benchmark.
// Drives G0/G1/G2 from a pseudo-random pattern LFSR, compacts the six
// registered s444 outputs into a 16-bit MISR and compares the final
// signature against GOLDEN_SIG.
// Ports:
//   CLOCK, RESET_N      clock shared with the s444 instance, async active-low reset
//   START               one-cycle pulse; starts a test from IDLE or DONE
//   DUT_G0..DUT_G2      registered drive of the benchmark primary inputs
//   RESP                {G168,G167,G119,G118,G108,G107} from the benchmark
//   BUSY, DONE          status (BUSY covers INIT, RUN and FLUSH)
//   PASS                final signature matched; only meaningful while DONE
//   SIGNATURE           live MISR contents
module s444_bist_ctrl
    import s444_bist_pkg::*;
#(
    parameter int unsigned PATTERN_COUNT = 1024,
    parameter int unsigned INIT_CYCLES   = 4,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED,
    parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              START,
    output logic              DUT_G0,
    output logic              DUT_G1,
    output logic              DUT_G2,
    input  logic [RESP_W-1:0] RESP,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [15:0]       SIGNATURE
);

    localparam int unsigned CW        = $clog2(PATTERN_COUNT + 1);
    localparam logic [CW-1:0] PAT_LAST  = CW'(PATTERN_COUNT - 1);
    localparam logic [7:0]    INIT_LAST = 8'(INIT_CYCLES - 1);

    state_t          state, state_nx;
    logic [7:0]      init_cnt;
    logic [CW-1:0]   pat_cnt;
    logic            start_run;
    logic            pat_shift;
    logic            cap_en;
    logic [15:0]     pat;
    logic [15:0]     resp_word;
    logic [15:0]     misr_final;

    assign start_run = START && (state == ST_IDLE || state == ST_DONE);
    assign resp_word = {{(16 - RESP_W){1'b0}}, RESP};
    // MISR value after the last capture, which happens on the FLUSH edge itself.
    assign misr_final = lfsr_step(SIGNATURE) ^ resp_word;

    // The pattern register runs one step ahead of the drive flops: the drive
    // for RUN cycle k is latched from pat while pat advances to pattern k+1.
    assign pat_shift = (state_nx == ST_RUN);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (START) state_nx = ST_INIT;
            ST_INIT:          if (init_cnt == INIT_LAST) state_nx = ST_RUN;
            ST_RUN:           if (pat_cnt == PAT_LAST) state_nx = ST_FLUSH;
            ST_FLUSH:         state_nx = ST_DONE;
            default:          state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            init_cnt <= '0;
            pat_cnt  <= '0;
        end else if (start_run) begin
            init_cnt <= '0;
            pat_cnt  <= '0;
        end else begin
            if (state == ST_INIT) init_cnt <= init_cnt + 8'd1;
            if (state == ST_RUN)  pat_cnt  <= (state_nx == ST_FLUSH) ? '0 : pat_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            DUT_G0 <= 1'b1;
            DUT_G1 <= 1'b0;
            DUT_G2 <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            PASS   <= 1'b0;
            cap_en <= 1'b0;
        end else begin
            // Response lags the drive by one cycle, so capture trails RUN by one.
            cap_en <= (state == ST_RUN);
            BUSY   <= (state_nx == ST_INIT) || (state_nx == ST_RUN) || (state_nx == ST_FLUSH);
            DONE   <= (state_nx == ST_DONE);
            if (pat_shift) begin
                DUT_G0 <= &pat[2:0];
                DUT_G1 <= pat[3];
                DUT_G2 <= pat[4];
            end else begin
                DUT_G0 <= 1'b1;
                DUT_G1 <= 1'b0;
                DUT_G2 <= 1'b0;
            end
            if (state == ST_FLUSH) begin
                PASS <= (misr_final == GOLDEN_SIG);
            end else if (start_run) begin
                PASS <= 1'b0;
            end
        end
    end

    bist_lfsr16 #(.RESET_VAL(LFSR_SEED)) u_pattern (
        .clk      (CLOCK),
        .rst_n    (RESET_N),
        .load     (start_run),
        .load_val (LFSR_SEED),
        .shift_en (pat_shift),
        .xor_in   (16'h0000),
        .q        (pat)
    );

    bist_lfsr16 #(.RESET_VAL(16'h0000)) u_misr (
        .clk      (CLOCK),
        .rst_n    (RESET_N),
        .load     (start_run),
        .load_val (16'h0000),
        .shift_en (cap_en),
        .xor_in   (resp_word),
        .q        (SIGNATURE)
    );

endmodule

// File: tb/tb_s444_bist_ctrl.sv
// Directed bench for s444_bist_ctrl. A small registered stand-in for the
// s444 netlist turns the drive into a response one cycle later, and the
// expected signatures come from an independent behavioural model.
module tb_s444_bist_ctrl;

    function automatic logic [5:0] fake_resp(input logic g0, input logic g1, input logic g2);
        return {g0 ^ g2, g1 & g2, g2, g1, g0, ~g1};
    endfunction

    function automatic logic [15:0] exp_sig(input int n, input int flip_at);
        logic [15:0] p;
        logic [15:0] m;
        logic [5:0]  r;
        logic        fb;
        p = 16'hACE1;
        m = 16'h0000;
        for (int k = 0; k < n; k++) begin
            r = fake_resp(p[0] & p[1] & p[2], p[3], p[4]);
            if (k == flip_at) r[0] = ~r[0];
            fb = m[15] ^ m[13] ^ m[12] ^ m[10];
            m  = {m[14:0], fb} ^ {10'b0, r};
            fb = p[15] ^ p[13] ^ p[12] ^ p[10];
            p  = {p[14:0], fb};
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD = exp_sig(8, -1);
    localparam logic [15:0] FLT  = exp_sig(8, 1);

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        START, START2;
    logic        flip, resp_x;
    logic        g0, g1, g2, busy, done, pass;
    logic        g0b, g1b, g2b, busyb, doneb, passb;
    logic [15:0] sig, sigb;
    logic [5:0]  resp_q, resp2_q, resp, resp2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) begin
        resp_q  <= fake_resp(g0, g1, g2);
        resp2_q <= fake_resp(g0b, g1b, g2b);
    end
    assign resp  = resp_x ? 6'bxxxxxx : (resp_q ^ {5'b0, flip});
    assign resp2 = resp2_q;

    s444_bist_ctrl #(.PATTERN_COUNT(8), .INIT_CYCLES(4), .LFSR_SEED(16'hACE1), .GOLDEN_SIG(GOLD)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START),
        .DUT_G0(g0), .DUT_G1(g1), .DUT_G2(g2), .RESP(resp),
        .BUSY(busy), .DONE(done), .PASS(pass), .SIGNATURE(sig)
    );

    s444_bist_ctrl #(.PATTERN_COUNT(1), .INIT_CYCLES(1), .LFSR_SEED(16'hACE1), .GOLDEN_SIG(16'h0001)) dut2 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START2),
        .DUT_G0(g0b), .DUT_G1(g1b), .DUT_G2(g2b), .RESP(resp2),
        .BUSY(busyb), .DONE(doneb), .PASS(passb), .SIGNATURE(sigb)
    );

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %h, expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_g0"},   0, 16'(g0),   16'h1);
        check({tag, "_g1"},   0, 16'(g1),   16'h0);
        check({tag, "_g2"},   0, 16'(g2),   16'h0);
        check({tag, "_busy"}, 0, 16'(busy), 16'h0);
        check({tag, "_done"}, 0, 16'(done), 16'h0);
        check({tag, "_pass"}, 0, 16'(pass), 16'h0);
        check({tag, "_sig"},  0, sig,       16'h0000);
    endtask

    // One complete test on the 8-pattern instance. START is high in cycle 0;
    // INIT is cycles 1..4, RUN 5..12, FLUSH 13, DONE from 14.
    task automatic do_run(input string tag, input int extra_start, input int flip_cyc,
                          input logic x_in_init, input logic [15:0] exp_signature,
                          input logic exp_pass);
        logic [15:0] p;
        logic        fb;
        p = 16'hACE1;
        START = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            START  = (c == extra_start);
            flip   = (c == flip_cyc);
            resp_x = x_in_init && (c <= 4);
            check({tag, "_busy"}, c, 16'(busy), 16'(c <= 13));
            check({tag, "_done"}, c, 16'(done), 16'(c >= 14));
            check({tag, "_pass"}, c, 16'(pass), 16'((c >= 14) && exp_pass));
            if (c <= 4) begin
                check({tag, "_init_g0"}, c, 16'(g0), 16'h1);
            end
            if (c == 5) begin
                check({tag, "_first_g"}, c, 16'({g2, g1, g0}), 16'h0);
            end
            if (c >= 5 && c <= 12) begin
                check({tag, "_run_g"}, c, 16'({g2, g1, g0}), 16'({p[4], p[3], p[0] & p[1] & p[2]}));
                fb = p[15] ^ p[13] ^ p[12] ^ p[10];
                p  = {p[14:0], fb};
            end
            if (c >= 14) begin
                check({tag, "_sig"},     c, sig, exp_signature);
                check({tag, "_done_g"},  c, 16'({g2, g1, g0}), 16'h1);
            end
        end
        START  = 1'b0;
        flip   = 1'b0;
        resp_x = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        START   = 1'b0;
        START2  = 1'b0;
        flip    = 1'b0;
        resp_x  = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        check("rst2_busy", 0, 16'(busyb), 16'h0);
        check("rst2_sig",  0, sigb,       16'h0000);

        RESET_N = 1'b1;
        repeat (10) tick();
        check_reset_vals("idle");

        // Clean run, then START from DONE with a START pulse inside RUN and
        // unknown RESP during INIT; both must land on the same signature.
        do_run("run1", 0, 0, 1'b0, GOLD, 1'b1);
        tick();
        tick();
        do_run("run2", 8, 0, 1'b1, GOLD, 1'b1);

        // One corrupted capture: RESP bit 0 inverted in the third RUN cycle.
        do_run("fault", 0, 7, 1'b0, FLT, 1'b0);

        // Asynchronous reset in the middle of RUN.
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (7) tick();
        RESET_N = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        RESET_N = 1'b1;
        tick();
        do_run("after_rst", 0, 0, 1'b0, GOLD, 1'b1);

        // Minimal configuration: INIT 1, RUN 1, FLUSH 1 with a single capture.
        START2 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            START2 = 1'b0;
            check("min_busy", c, 16'(busyb), 16'((c >= 1) && (c <= 3)));
            check("min_done", c, 16'(doneb), 16'(c >= 4));
            check("min_pass", c, 16'(passb), 16'(c >= 4));
            if (c == 3) check("min_sig_flush", c, sigb, 16'h0000);
            if (c >= 4) check("min_sig_done",  c, sigb, 16'h0001);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/s444_bist_ctrl.md
Name: s444_bist_ctrl

Overview:
- Built-in self-test controller for the s444 sequential benchmark.
- Drives the benchmark's three primary inputs (G0, G1, G2) from a pseudo-random pattern source.
- Compresses the six registered primary outputs into a signature and compares it against a golden value.
- Sits beside the s444 instance in the test harness, at the opposite end of its primary I/O.

Parameters:
PATTERN_COUNT, 1024, number of RUN cycles (patterns applied); legal range 1..65535
INIT_CYCLES, 4, cycles G0 is held high to clear the DUT before RUN; legal range 1..255
LFSR_SEED, 16'hACE1, pattern LFSR seed; must be nonzero
GOLDEN_SIG, 16'h0000, expected final MISR value, computed by the reference model per netlist

Ports:
CLOCK  input  1  rising-edge clock shared with the DUT
RESET_N  input  1  asynchronous active-low reset
START  input  1  single-cycle pulse that starts a test from IDLE or DONE
DUT_G0  output  1  drives DUT G0 (synchronous clear input of the benchmark)
DUT_G1  output  1  drives DUT G1
DUT_G2  output  1  drives DUT G2
RESP  input  6  DUT outputs packed as {G168,G167,G119,G118,G108,G107}
BUSY  output  1  high in INIT, RUN and FLUSH
DONE  output  1  high in DONE state
PASS  output  1  SIGNATURE==GOLDEN_SIG; valid only while DONE, else 0
SIGNATURE  output  16  current MISR contents

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, DUT_G0=1, DUT_G1=0, DUT_G2=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=0, LFSR=LFSR_SEED, pattern counter=0.
- States:
  - IDLE -> INIT on START.
  - INIT: hold DUT_G0=1 for INIT_CYCLES, then go to RUN.
  - RUN: lasts PATTERN_COUNT cycles, then go to FLUSH.
  - FLUSH: lasts 1 cycle, then go to DONE.
  - DONE -> INIT on START.
- Entering INIT from IDLE or DONE: LFSR reloads LFSR_SEED, MISR clears to 0, counter clears, PASS drops.
- START is ignored in INIT, RUN and FLUSH.
- IDLE and DONE: DUT_G0=1, DUT_G1=DUT_G2=0.
- Pattern LFSR:
  - 16-bit Fibonacci, shifts left: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances once per RUN cycle.
  - RUN drive: DUT_G0 = &lfsr[2:0] (clear probability 1/8), DUT_G1=lfsr[3], DUT_G2=lfsr[4].
  - The first RUN cycle uses the seed value itself.
- Latency: every DUT output is a flop, so the response to the pattern driven in cycle t appears on RESP in cycle t+1.
- MISR capture:
  - capture_en = RUN delayed one cycle, so it is high on RUN cycles 2..N and on FLUSH.
  - This gives exactly PATTERN_COUNT captures.
  - The response during the first RUN cycle (post-INIT state) is not captured.
- MISR update when capture_en: next = {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ {10'b0, RESP}.
- SIGNATURE mirrors the MISR continuously.
- PASS is registered on the FLUSH->DONE transition.
- Counter wraps to 0 only on the transition into FLUSH. Its width is sized from PATTERN_COUNT.
- Total BUSY duration = INIT_CYCLES + PATTERN_COUNT + 1 cycles.
- Async reset asserted mid-operation: immediate return to reset values; DUT_G0=1 so the DUT is held cleared.
- RESP X/Z during INIT is not captured and must not corrupt the MISR.

Decomposition:
- Shared package s444_bist_pkg holds:
  - state enum (IDLE, INIT, RUN, FLUSH, DONE)
  - LFSR tap constant
  - default seed
  - RESP_W=6
  - RESP bit-index constants for G107..G168
- One sub-module, bist_lfsr16, serves both uses:
  - ports: clock, async reset, load, load value, shift enable, parallel XOR input, state out
  - instantiated twice: as the pattern LFSR (XOR input 0) and as the MISR.

Test Plan:
- Reset -> DUT_G0=1, DUT_G1=0, DUT_G2=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=16'h0000; hold 10 cycles with START=0 -> unchanged.
- INIT_CYCLES=4, PATTERN_COUNT=8, START pulse at cycle 0 -> BUSY high cycles 1..13, DONE from cycle 14; DUT_G0=1 cycles 1..4; cycle 5 drives G0=0,G1=0,G2=0 (seed ACE1).
- Full run against the real s444 netlist, PATTERN_COUNT=1024, GOLDEN_SIG from the model -> SIGNATURE equals model, PASS=1. Same run with RESP bit 0 forced inverted on one capture cycle -> PASS=0.
- START pulsed during RUN -> no restart, same cycle count and signature. START in DONE -> second run gives an identical SIGNATURE.
- RESET_N low for 1 cycle mid-RUN -> all outputs at reset values in the same cycle; next START run matches the clean-run signature.
- PATTERN_COUNT=1, INIT_CYCLES=1 -> BUSY exactly 3 cycles, exactly one MISR capture (during FLUSH), SIGNATURE = {10'b0, RESP}.
